// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - binary16 field constants, slice helpers and divider FSM states
// Shared by the fp16 multiplier and divider; no ports.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;
    localparam int QBITS = MAN_W + 2;
    localparam int CNT_W = 4;

    localparam logic [15:0] FP16_ZERO    = 16'h0000;
    localparam logic [14:0] FP16_INF_MAG = 15'h7C00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV     = 2'd1,
        ST_NORM    = 2'd2,
        ST_SPECIAL = 2'd3
    } fp16_state_e;

    function automatic logic fp_sign(input logic [15:0] v);
        return v[15];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [15:0] v);
        return v[14:10];
    endfunction

    function automatic logic [MAN_W-1:0] fp_man(input logic [15:0] v);
        return v[9:0];
    endfunction

    // No denormals: any value with a zero magnitude field is treated as zero.
    function automatic logic fp_is_zero(input logic [15:0] v);
        return (v[14:0] == 15'd0);
    endfunction

endpackage

// File: rtl/fp16_divide_if.sv
// rtl/fp16_divide_if.sv - start/result handshake bundle for the fp16 divider
// in_A, in_B, in_En : operands and start strobe, driven by the master
// out_Out, out_Ready, out_Busy : quotient, result pulse, busy flag, driven by the divider
interface fp16_divide_if;

    logic [15:0] in_A;
    logic [15:0] in_B;
    logic        in_En;
    logic [15:0] out_Out;
    logic        out_Ready;
    logic        out_Busy;

    modport master (
        output in_A, in_B, in_En,
        input  out_Out, out_Ready, out_Busy
    );

    modport slave (
        input  in_A, in_B, in_En,
        output out_Out, out_Ready, out_Busy
    );

endinterface

// File: rtl/fp16_div_iter.sv
// rtl/fp16_div_iter.sv - restoring mantissa divider, one quotient bit per clock
// clk, rst     : clock, asynchronous active-high reset
// start_i      : load operands and begin QBITS iterations
// a_man_i      : dividend stored mantissa (hidden one added here)
// b_man_i      : divisor stored mantissa (hidden one added here)
// done_o       : high during the last iteration cycle; q_o is final after that edge
// q_o          : quotient floor({1,a}*2^11 / {1,b})
module fp16_div_iter
    import fp16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [MAN_W-1:0] a_man_i,
    input  logic [MAN_W-1:0] b_man_i,
    output logic             done_o,
    output logic [QBITS-1:0] q_o
);

    logic [QBITS-1:0] rem_q, rem_d;
    logic [MAN_W:0]   div_q;
    logic [QBITS-1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic             ge;
    logic [QBITS-1:0] diff;

    // Remainder stays below the divisor after each step, so the left shift
    // never overflows the QBITS-wide register.
    always_comb begin
        ge    = (rem_q >= {1'b0, div_q});
        diff  = rem_q - {1'b0, div_q};
        rem_d = ge ? {diff[QBITS-2:0], 1'b0} : {rem_q[QBITS-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            rem_q    <= {1'b0, 1'b1, a_man_i};
            div_q    <= {1'b1, b_man_i};
            quo_q    <= '0;
            cnt_q    <= CNT_W'(QBITS - 1);
            active_q <= 1'b1;
        end else if (active_q) begin
            rem_q <= rem_d;
            quo_q <= {quo_q[QBITS-2:0], ge};
            if (cnt_q == '0) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign done_o = active_q && (cnt_q == '0);
    assign q_o    = quo_q;

endmodule

// File: rtl/fp16_divide.sv
// rtl/fp16_divide.sv - iterative binary16 divider, truncating, no denormals or NaN
// clk, rst : clock, asynchronous active-high reset
// bus      : slave side of fp16_divide_if (in_A/in_B/in_En in, out_Out/out_Ready/out_Busy out)
module fp16_divide
    import fp16_pkg::*;
(
    input logic         clk,
    input logic         rst,
    fp16_divide_if.slave bus
);

    fp16_state_e      state_q;
    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic             a_zero_q;
    logic [15:0]      out_q;
    logic             ready_q;
    logic             busy_q;

    logic             sign_d;
    logic [EXP_W-1:0] exp_d;
    logic             a_zero_d;
    logic             special_d;
    logic             accept;
    logic             start_div;
    logic             iter_done;
    logic [QBITS-1:0] quo;

    // Exponent wraps modulo 2^EXP_W by design; overflow is not flagged.
    always_comb begin
        sign_d    = fp_sign(bus.in_A) ^ fp_sign(bus.in_B);
        exp_d     = fp_exp(bus.in_A) - fp_exp(bus.in_B) + EXP_W'(BIAS);
        a_zero_d  = fp_is_zero(bus.in_A);
        special_d = a_zero_d || fp_is_zero(bus.in_B);
        accept    = (state_q == ST_IDLE) && bus.in_En;
        start_div = accept && !special_d;
    end

    fp16_div_iter u_iter (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_div),
        .a_man_i (fp_man(bus.in_A)),
        .b_man_i (fp_man(bus.in_B)),
        .done_o  (iter_done),
        .q_o     (quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            a_zero_q <= 1'b0;
            out_q    <= FP16_ZERO;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        sign_q   <= sign_d;
                        exp_q    <= exp_d;
                        a_zero_q <= a_zero_d;
                        busy_q   <= 1'b1;
                        state_q  <= special_d ? ST_SPECIAL : ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (iter_done) begin
                        state_q <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    // Quotient lies in [2^10, 2^12); a clear top bit means the
                    // mantissa ratio was below one, so shift left and drop an exponent.
                    if (quo[QBITS-1]) begin
                        out_q <= {sign_q, exp_q, quo[QBITS-2:1]};
                    end else begin
                        out_q <= {sign_q, exp_q - 1'b1, quo[MAN_W-1:0]};
                    end
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_SPECIAL: begin
                    // Zero dividend wins over zero divisor, so 0/0 yields zero.
                    out_q   <= a_zero_q ? FP16_ZERO : {sign_q, FP16_INF_MAG};
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_Out   = out_q;
    assign bus.out_Ready = ready_q;
    assign bus.out_Busy  = busy_q;

endmodule

// File: tb/tb_fp16_divide.sv
// tb/tb_fp16_divide.sv - scoreboard bench for fp16_divide
module tb_fp16_divide;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp16_divide_if dut_if();

    fp16_divide u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb[$];
    logic        prev_ready = 1'b0;
    logic [15:0] exp_val;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int   na, nb, q, e, frac;
        s = a[15] ^ b[15];
        if (a[14:0] == 15'd0) return 16'h0000;
        if (b[14:0] == 15'd0) return {s, 15'h7C00};
        na = 1024 + int'(a[9:0]);
        nb = 1024 + int'(b[9:0]);
        q  = (na * 2048) / nb;
        e  = int'(a[14:10]) - int'(b[14:10]) + 15;
        if (q >= 2048) begin
            frac = (q / 2) % 1024;
        end else begin
            frac = q % 1024;
            e    = e - 1;
        end
        return {s, 5'(e & 31), 10'(frac)};
    endfunction

    always @(posedge clk) begin
        #1;
        if (dut_if.out_Ready === 1'b1) begin
            check_eq("ready_width", 32'(prev_ready), 32'd0);
            if (sb.size() == 0) begin
                check_eq("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_val = sb.pop_front();
                check_eq("result", 32'(dut_if.out_Out), 32'(exp_val));
            end
        end
        prev_ready = dut_if.out_Ready;
    end

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] expv);
        dut_if.in_A  = a;
        dut_if.in_B  = b;
        dut_if.in_En = 1'b1;
        sb.push_back(expv);
        @(posedge clk);
        #1;
        dut_if.in_En = 1'b0;
        dut_if.in_A  = 16'($urandom);
        dut_if.in_B  = 16'($urandom);
        check_eq("busy_after_accept", 32'(dut_if.out_Busy), 32'd1);
    endtask

    task automatic wait_ready(input int lat);
        int n;
        n = 1;
        while (dut_if.out_Ready !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("latency", 32'(n), 32'(lat));
        check_eq("busy_in_ready", 32'(dut_if.out_Busy), 32'd0);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] expv, input int lat);
        start_op(a, b, expv);
        wait_ready(lat);
    endtask

    initial begin
        logic [15:0] ra, rb;
        dut_if.in_A  = 16'h0000;
        dut_if.in_B  = 16'h0000;
        dut_if.in_En = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_out", 32'(dut_if.out_Out), 32'h0);
        check_eq("reset_ready", 32'(dut_if.out_Ready), 32'd0);
        check_eq("reset_busy", 32'(dut_if.out_Busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(16'h4600, 16'h4000, 16'h4200, 14);
        do_op(16'h3C00, 16'h4200, 16'h3555, 14);
        do_op(16'hBE00, 16'h3800, 16'hC200, 14);
        do_op(16'h0000, 16'h4000, 16'h0000, 2);
        do_op(16'h3C00, 16'h8000, 16'hFC00, 2);
        do_op(16'h0000, 16'h0000, 16'h0000, 2);

        // Start during DIV must be ignored; start in the ready cycle must be taken.
        start_op(16'h4600, 16'h4000, 16'h4200);
        repeat (3) @(posedge clk);
        #1;
        dut_if.in_A  = 16'h4000;
        dut_if.in_B  = 16'h4000;
        dut_if.in_En = 1'b1;
        @(posedge clk);
        #1;
        dut_if.in_En = 1'b0;
        check_eq("busy_during_div", 32'(dut_if.out_Busy), 32'd1);
        wait_ready(14 - 4);
        start_op(16'h3C00, 16'h4200, 16'h3555);
        wait_ready(14);

        // Asynchronous reset in the middle of the iterations.
        start_op(16'h4600, 16'h4000, 16'h4200);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_out", 32'(dut_if.out_Out), 32'h0);
        check_eq("rst_mid_ready", 32'(dut_if.out_Ready), 32'd0);
        check_eq("rst_mid_busy", 32'(dut_if.out_Busy), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        do_op(16'h4600, 16'h4000, 16'h4200, 14);

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom_range(16'h0400, 16'hFBFF));
            rb = 16'($urandom_range(16'h0400, 16'hFBFF));
            do_op(ra, rb, model(ra, rb), (ra[14:0] == 15'd0 || rb[14:0] == 15'd0) ? 2 : 14);
        end

        repeat (20) @(posedge clk);
        #1;
        check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
